// File: rtl/ram_16x8_ctrl.sv
// ram_16x8_ctrl: initiator-side controller for a 16x8 synchronous RAM.
// It takes single or burst read/write commands on a valid/ready request
// channel and returns read beats on a valid/ready response channel.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds its payload stable
// while valid=1 and ready=0. valid never waits on ready.
//
// Optional build macro RAM_CTRL_FILL_INC_EN: when it is defined, a write
// burst writes a ramp (req_wdata, +1, +2, ... mod 256). When it is not
// defined, every beat writes req_wdata unchanged.
//
// All outputs are registered. The always_comb block computes the next value
// of every register, and the always_ff block loads those values.
module ram_16x8_ctrl #(
    parameter int RD_LAT = 1,
    parameter int AW     = 4,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          busy,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [3:0]    beats, beats_d;     // beats remaining after the current one
    logic [1:0]    lat, lat_d;         // RD_WAIT edges still to count, minus 1
    logic          req_ready_d, busy_d, ram_wr_d, rsp_valid_d;
    logic [AW-1:0] ram_addr_d, rsp_addr_d;
    logic [DW-1:0] ram_din_d, rsp_data_d;

    // ram_addr doubles as the current burst address for reads and writes.
    // Next-state and next-output logic: every register keeps its value
    // unless a branch below updates it.
    always_comb begin
        state_d     = state;
        beats_d     = beats;
        lat_d       = lat;
        ram_wr_d    = ram_wr;
        ram_addr_d  = ram_addr;
        ram_din_d   = ram_din;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_addr_d  = rsp_addr;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    beats_d    = req_len;
                    ram_addr_d = req_addr;
                    ram_din_d  = req_wdata;
                    if (req_wr) begin
                        state_d  = WRITE;
                        ram_wr_d = 1'b1;
                    end else begin
                        state_d  = RD_ISSUE;
                        ram_wr_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (beats == 4'd0) begin
                    state_d  = IDLE;
                    ram_wr_d = 1'b0;
                end else begin
                    beats_d    = beats - 4'd1;
                    ram_addr_d = AW'(ram_addr + 1'b1);
`ifdef RAM_CTRL_FILL_INC_EN
                    ram_din_d  = DW'(ram_din + 1'b1);
`else
                    ram_din_d  = ram_din;
`endif
                end
            end
            RD_ISSUE: begin
                // The RAM samples ram_addr on this edge. The wait count starts here.
                state_d = RD_WAIT;
                lat_d   = 2'(RD_LAT - 1);
            end
            RD_WAIT: begin
                if (lat == 2'd0) begin
                    rsp_data_d  = ram_dout;
                    rsp_addr_d  = ram_addr;
                    rsp_valid_d = 1'b1;
                    state_d     = RD_RESP;
                end else begin
                    lat_d = lat - 2'd1;
                end
            end
            RD_RESP: begin
                // rsp_valid is always 1 here, so rsp_ready alone completes the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (beats == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d    = beats - 4'd1;
                        ram_addr_d = AW'(ram_addr + 1'b1);
                        state_d    = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                ram_wr_d = 1'b0;
            end
        endcase
        // Both flags follow the next state, so they switch on the same edge as the state.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers. A synchronous reset drops any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beats     <= 4'd0;
            lat       <= 2'd0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else begin
            state     <= state_d;
            beats     <= beats_d;
            lat       <= lat_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            ram_wr    <= ram_wr_d;
            ram_addr  <= ram_addr_d;
            ram_din   <= ram_din_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_addr  <= rsp_addr_d;
        end
    end

endmodule
